// File: rtl/mix_columns_iter_if.sv
// Handshake bundle for the iterative MixColumns engine.
//   in_valid/in_ready   : block offer and accept, carrying state_in and inv
//   out_valid/out_ready : result offer and accept, carrying state_out
//   busy                : engine is in CALC or DONE
// The master modport is the block producer and result consumer. The slave
// modport is the engine.
interface mix_columns_iter_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] state_in;
   logic         inv;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] state_out;
   logic         busy;

   modport master (
      output in_valid, state_in, inv, out_ready,
      input  in_ready, out_valid, state_out, busy
   );

   modport slave (
      input  in_valid, state_in, inv, out_ready,
      output in_ready, out_valid, state_out, busy
   );
endinterface

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns engine.
// Each CALC cycle transforms COLS_PER_CYCLE columns of the working register.
// Column c sits at bits [127-32c -: 32], and row 0 is the MSB byte of each column.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of mix_columns_iter_if (block in, result out, busy)
module mix_columns_iter #(
   parameter int unsigned COLS_PER_CYCLE = 1
) (
   input  logic                clk,
   input  logic                rst,
   mix_columns_iter_if.slave   bus
);

   localparam int unsigned NUM_COLS = 4;
   // The counter value of the final column group. The 2-bit counter wraps to 0 after it.
   localparam logic [1:0]  LAST_CNT = 2'(NUM_COLS - COLS_PER_CYCLE);

   // Reject unsupported column widths at elaboration
   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t        state_q, state_d;
   logic [1:0]    cnt_q;
   logic [127:0]  work_q, work_d;
   logic          inv_q;
   logic          out_valid_q;
   logic [127:0]  state_out_q;
   logic          busy_q;
   logic          accept_c;
   logic          last_c;

   // GF(2^8) multiply by 2 modulo 0x11B
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   // 8-bit 2:1 select between the forward and inverse products
   function automatic logic [7:0] sel8(input logic sel, input logic [7:0] a, input logic [7:0] b);
      return sel ? b : a;
   endfunction

   // One column through MixColumns (inv=0) or InvMixColumns (inv=1)
   function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
      logic [7:0] a  [4];
      logic [7:0] x2 [4];
      logic [7:0] x4 [4];
      logic [7:0] x8 [4];
      logic [7:0] m3 [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] fwd, bwd;
      logic [31:0] res;
      res = '0;
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31 - 8*i -: 8];
         x2[i] = xtime(a[i]);
         x4[i] = xtime(x2[i]);
         x8[i] = xtime(x4[i]);
         m3[i] = x2[i] ^ a[i];
         m9[i] = x8[i] ^ a[i];
         mb[i] = x8[i] ^ x2[i] ^ a[i];
         md[i] = x8[i] ^ x4[i] ^ a[i];
         me[i] = x8[i] ^ x4[i] ^ x2[i];
      end
      for (int r = 0; r < 4; r++) begin
         fwd = x2[r] ^ m3[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
         bwd = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
         res[31 - 8*r -: 8] = sel8(inv, fwd, bwd);
      end
      return res;
   endfunction

   // Column indices and transformed values for the current group
   logic [1:0]  col_idx [COLS_PER_CYCLE];
   logic [31:0] col_mix [COLS_PER_CYCLE];

   for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
      assign col_idx[g] = cnt_q + 2'(g);
      // Column c starts at bit 32*(3-c), and 3-c is ~c for a 2-bit index.
      assign col_mix[g] = mix_col(work_q[{~col_idx[g], 5'b0} +: 32], inv_q);
   end

   // Working register with the current group replaced
   always_comb begin
      work_d = work_q;
      for (int g = 0; g < COLS_PER_CYCLE; g++) begin
         work_d[{~col_idx[g], 5'b0} +: 32] = col_mix[g];
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state and control decode
   always_comb begin
      state_d  = state_q;
      accept_c = 1'b0;
      last_c   = 1'b0;
      case (state_q)
         IDLE: begin
            accept_c = bus.in_valid;
            if (bus.in_valid) state_d = CALC;
         end
         CALC: begin
            last_c = (cnt_q == LAST_CNT);
            if (cnt_q == LAST_CNT) state_d = DONE;
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         work_q      <= '0;
         inv_q       <= 1'b0;
         out_valid_q <= 1'b0;
         state_out_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         busy_q <= (state_d != IDLE);
         if (accept_c) begin
            work_q <= bus.state_in;
            inv_q  <= bus.inv;
            cnt_q  <= '0;
         end
         if (state_q == CALC) begin
            work_q <= work_d;
            cnt_q  <= cnt_q + 2'(COLS_PER_CYCLE);
            if (last_c) begin
               state_out_q <= work_d;
               out_valid_q <= 1'b1;
            end
         end
         if (state_q == DONE && bus.out_ready) out_valid_q <= 1'b0;
      end
   end

   // in_ready is decoded from state and forced low while reset is asserted
   assign bus.in_ready  = (state_q == IDLE) && !rst;
   assign bus.out_valid = out_valid_q;
   assign bus.state_out = state_out_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Directed bench for mix_columns_iter.
// Instances m (1 column/cycle), b2 (2) and b4 (4) share clk and rst.
module tb_mix_columns_iter;

   logic clk;
   logic rst;

   mix_columns_iter_if m ();
   mix_columns_iter_if b2 ();
   mix_columns_iter_if b4 ();

   mix_columns_iter #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(m));
   mix_columns_iter #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
   mix_columns_iter #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

   localparam logic [127:0] V1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] R1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [127:0] V2 = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
   localparam logic [127:0] R2 = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;

   int n_checks = 0;
   int n_pass   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %h want %h", tag, got, exp);
      else n_pass++;
   endtask

   // Offer one block to m at #1 after an edge, then drop in_valid after the accept edge
   task automatic send(input logic [127:0] d, input logic iv);
      m.in_valid = 1'b1;
      m.state_in = d;
      m.inv      = iv;
      @(posedge clk); #1;
      m.in_valid = 1'b0;
   endtask

   // Count edges until m.out_valid is seen, with a bounded wait
   task automatic wait_valid(output int lat);
      int n;
      n = 0;
      while (!m.out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      lat = n;
   endtask

   // Consume the pending result on m
   task automatic drain();
      m.out_ready = 1'b1;
      @(posedge clk); #1;
      m.out_ready = 1'b0;
   endtask

   initial begin
      int lat, lat2, lat4, bad;
      int t_prev, n_acc, n_res;
      logic acc, con;
      logic [127:0] vecs [2];
      logic [127:0] exps [4];

      vecs[0] = V1; vecs[1] = V2;
      exps[0] = R1; exps[1] = R2; exps[2] = R1; exps[3] = R2;

      rst = 1'b1;
      m.in_valid = 1'b0;  m.state_in = '0;  m.inv = 1'b0;  m.out_ready = 1'b0;
      b2.in_valid = 1'b0; b2.state_in = '0; b2.inv = 1'b0; b2.out_ready = 1'b0;
      b4.in_valid = 1'b0; b4.state_in = '0; b4.inv = 1'b0; b4.out_ready = 1'b0;

      // Reset state
      #12;
      check("rst_out_valid", 128'(m.out_valid), 128'(0));
      check("rst_state_out", m.state_out, 128'h0);
      check("rst_busy", 128'(m.busy), 128'(0));
      check("rst_in_ready", 128'(m.in_ready), 128'(0));
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_in_ready", 128'(m.in_ready), 128'(1));

      // Forward block. An early out_ready must not cut the result short.
      send(V1, 1'b0);
      m.out_ready = 1'b1;
      wait_valid(lat);
      check("fwd_latency", 128'(lat), 128'(4));
      check("fwd_result", m.state_out, R1);
      check("fwd_busy", 128'(m.busy), 128'(1));
      @(posedge clk); #1;
      m.out_ready = 1'b0;
      check("fwd_valid_drop", 128'(m.out_valid), 128'(0));

      // Inverse block with inv toggled after the accept
      send(V2, 1'b1);
      m.inv = 1'b0;
      wait_valid(lat);
      check("inv_latency", 128'(lat), 128'(4));
      check("inv_result", m.state_out, R2);
      drain();

      // Backpressure for 10 cycles with a competing in_valid
      send(V1, 1'b0);
      wait_valid(lat);
      m.in_valid = 1'b1;
      m.state_in = V2;
      m.inv      = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (m.state_out !== R1 || m.out_valid !== 1'b1 || m.in_ready !== 1'b0) bad++;
      end
      check("bp_hold", 128'(bad), 128'(0));
      m.in_valid = 1'b0;
      m.out_ready = 1'b1;
      @(posedge clk); #1;
      m.out_ready = 1'b0;
      check("bp_valid_drop", 128'(m.out_valid), 128'(0));
      check("bp_in_ready", 128'(m.in_ready), 128'(1));
      check("bp_out_kept", m.state_out, R1);
      @(posedge clk); #1;
      check("bp_no_accept", 128'(m.busy), 128'(0));

      // Back-to-back with in_valid held and out_ready tied high
      m.out_ready = 1'b1;
      m.in_valid  = 1'b1;
      m.state_in  = vecs[0];
      m.inv       = 1'b0;
      t_prev = 0; n_acc = 0; n_res = 0;
      for (int t = 0; t < 60 && n_res < 4; t++) begin
         acc = m.in_valid & m.in_ready;
         con = m.out_valid & m.out_ready;
         if (con) begin
            check($sformatf("b2b_res%0d", n_res), m.state_out, exps[n_res]);
            n_res++;
         end
         @(posedge clk); #1;
         if (acc) begin
            if (n_acc > 0) check("b2b_gap", 128'(t - t_prev), 128'(6));
            t_prev = t;
            n_acc++;
            // Switching inv here also changes it while the previous block is in CALC.
            if (n_acc < 4) begin
               m.state_in = vecs[n_acc % 2];
               m.inv      = 1'((n_acc % 2) != 0);
            end else begin
               m.in_valid = 1'b0;
            end
         end
      end
      check("b2b_count", 128'(n_res), 128'(4));
      m.out_ready = 1'b0;
      @(posedge clk); #1;

      // Asynchronous reset pulse in the middle of CALC
      send(V1, 1'b0);
      @(posedge clk); #1;
      #3 rst = 1'b1;
      #1;
      check("arst_out_valid", 128'(m.out_valid), 128'(0));
      check("arst_state_out", m.state_out, 128'h0);
      check("arst_busy", 128'(m.busy), 128'(0));
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (m.out_valid !== 1'b0) bad++;
      end
      check("arst_no_pulse", 128'(bad), 128'(0));
      send(V2, 1'b1);
      wait_valid(lat);
      check("arst_next_lat", 128'(lat), 128'(4));
      check("arst_next_res", m.state_out, R2);
      drain();

      // Column-width sweep on the 2- and 4-column instances
      check("sweep_ready", 128'({b2.in_ready, b4.in_ready}), 128'(2'b11));
      b2.in_valid = 1'b1; b2.state_in = V1; b2.inv = 1'b0;
      b4.in_valid = 1'b1; b4.state_in = V1; b4.inv = 1'b0;
      @(posedge clk); #1;
      b2.in_valid = 1'b0;
      b4.in_valid = 1'b0;
      lat2 = 20; lat4 = 20;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (b2.out_valid && lat2 == 20) lat2 = n;
         if (b4.out_valid && lat4 == 20) lat4 = n;
      end
      check("c2_latency", 128'(lat2), 128'(2));
      check("c4_latency", 128'(lat4), 128'(1));
      check("c2_result", b2.state_out, R1);
      check("c4_result", b4.state_out, R1);
      b2.out_ready = 1'b1;
      b4.out_ready = 1'b1;
      @(posedge clk); #1;
      check("c24_drop", 128'({b2.out_valid, b4.out_valid}), 128'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
